wb_ahb_bridge: RTL and testbench



---
 rtl/wb_ahb_bridge.sv | 160 ++++++++++++++++
 tb/tb_wb_ahb_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ahb_bridge.sv
// Wishbone classic-cycle slave to single-master AHB initiator bridge.
// Each WB single read/write becomes one AHB SINGLE NONSEQ word transfer.
module wb_ahb_bridge #(
   parameter int AWIDTH    = 32,
   parameter int DWIDTH    = 32,
   parameter int MAX_RETRY = 4
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] adr_i,
   input  logic [DWIDTH-1:0] dat_i,
   output logic [DWIDTH-1:0] dat_o,
   output logic              ack_o,
   output logic              err_o,
   output logic [AWIDTH-1:0] haddr,
   output logic [1:0]        htrans,
   output logic [2:0]        hburst,
   output logic [2:0]        hsize,
   output logic              hwrite,
   output logic [DWIDTH-1:0] hwdata,
   input  logic              hready,
   input  logic [DWIDTH-1:0] hrdata,
   input  logic [1:0]        hresp
);

   localparam int RCW = $clog2(MAX_RETRY + 1);
   localparam logic [RCW-1:0] MAX_RETRY_C = RCW'(MAX_RETRY);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_e;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] haddr_q, haddr_d;
   logic [1:0]        htrans_q, htrans_d;
   logic              hwrite_q, hwrite_d;
   logic [DWIDTH-1:0] hold_q, hold_d;
   logic [DWIDTH-1:0] hwdata_q, hwdata_d;
   logic [DWIDTH-1:0] dat_q, dat_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [RCW-1:0]    retry_q, retry_d;
   logic [RCW-1:0]    retry_inc;

   // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      haddr_d   = haddr_q;
      htrans_d  = HTRANS_IDLE;
      hwrite_d  = hwrite_q;
      hold_d    = hold_q;
      hwdata_d  = hwdata_q;
      dat_d     = dat_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      retry_d   = retry_q;
      retry_inc = retry_q + RCW'(1);

      case (state_q)
         ST_IDLE: begin
            if (cyc_i && stb_i) begin
               haddr_d  = adr_i;
               hwrite_d = we_i;
               hold_d   = dat_i;
               htrans_d = HTRANS_NONSEQ;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (hready) begin
               hwdata_d = hwrite_q ? hold_q : '0;
               state_d  = ST_DATA;
            end else begin
               htrans_d = HTRANS_NONSEQ;
            end
         end
         ST_DATA: begin
            if (hready) begin
               if (!cyc_i) begin
                  // Master abandoned the cycle: the AHB beat finished, report nothing.
                  retry_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  case (hresp)
                     HRESP_OKAY: begin
                        if (!hwrite_q) dat_d = hrdata;
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                     end
                     HRESP_ERROR: begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                     end
                     default: begin
                        retry_d = retry_inc;
                        if (retry_inc < MAX_RETRY_C) begin
                           htrans_d = HTRANS_NONSEQ;
                           state_d  = ST_ADDR;
                        end else begin
                           err_d   = 1'b1;
                           state_d = ST_RESP;
                        end
                     end
                  endcase
               end
            end
         end
         ST_RESP: begin
            // Skipping a cycle in IDLE here keeps a held stb_i from being taken twice.
            retry_d = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q  <= ST_IDLE;
         haddr_q  <= '0;
         htrans_q <= HTRANS_IDLE;
         hwrite_q <= 1'b0;
         hold_q   <= '0;
         hwdata_q <= '0;
         dat_q    <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         retry_q  <= '0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         htrans_q <= htrans_d;
         hwrite_q <= hwrite_d;
         hold_q   <= hold_d;
         hwdata_q <= hwdata_d;
         dat_q    <= dat_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         retry_q  <= retry_d;
      end
   end

   assign haddr  = haddr_q;
   assign htrans = htrans_q;
   assign hburst = 3'b000;
   assign hsize  = 3'b010;
   assign hwrite = hwrite_q;
   assign hwdata = hwdata_q;
   assign dat_o  = dat_q;
   assign ack_o  = ack_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_wb_ahb_bridge.sv
// Directed self-checking bench for wb_ahb_bridge; the AHB slave is scripted per test.
module tb_wb_ahb_bridge;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] R_OKAY = 2'b00;
   localparam logic [1:0] R_ERR  = 2'b01;
   localparam logic [1:0] R_RTRY = 2'b10;

   logic        hclk, hresetn;
   logic        cyc_i, stb_i, we_i;
   logic [31:0] adr_i, dat_i, dat_o;
   logic        ack_o, err_o;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0]  htrans, hresp;
   logic [2:0]  hburst, hsize;
   logic        hwrite, hready;

   int checks   = 0;
   int failures = 0;

   wb_ahb_bridge dut (
      .hclk(hclk), .hresetn(hresetn),
      .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i),
      .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
      .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize),
      .hwrite(hwrite), .hwdata(hwdata),
      .hready(hready), .hrdata(hrdata), .hresp(hresp)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
   task automatic step();
      @(posedge hclk);
      @(negedge hclk);
   endtask

   task automatic test_reset();
      hresetn = 1'b0;
      repeat (2) @(negedge hclk);
      checks++;
      if ({haddr, htrans, hburst, hsize, hwrite, hwdata, dat_o, ack_o, err_o} !==
          {32'h0, T_IDLE, 3'b000, 3'b010, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_values got haddr=%h htrans=%b hburst=%b hsize=%b hwrite=%b hwdata=%h dat_o=%h ack=%b err=%b",
                  haddr, htrans, hburst, hsize, hwrite, hwdata, dat_o, ack_o, err_o);
      end
      hresetn = 1'b1;
      step();
      checks++;
      if (htrans !== T_IDLE || ack_o !== 1'b0) begin
         failures++; $display("FAIL idle_after_reset got htrans=%b ack=%b exp 00/0", htrans, ack_o);
      end
   endtask

   task automatic test_write();
      cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 32'h40; dat_i = 32'hDEADBEEF;
      step();
      checks++;
      if (htrans !== T_NSEQ || haddr !== 32'h40 || hwrite !== 1'b1 || ack_o !== 1'b0) begin
         failures++; $display("FAIL wr_c1 got htrans=%b haddr=%h hwrite=%b ack=%b exp 10/40/1/0", htrans, haddr, hwrite, ack_o);
      end
      step();
      checks++;
      if (htrans !== T_IDLE || hwdata !== 32'hDEADBEEF || ack_o !== 1'b0) begin
         failures++; $display("FAIL wr_c2 got htrans=%b hwdata=%h ack=%b exp 00/deadbeef/0", htrans, hwdata, ack_o);
      end
      step();
      checks++;
      if (ack_o !== 1'b1 || err_o !== 1'b0) begin
         failures++; $display("FAIL wr_ack_c3 got ack=%b err=%b exp 1/0", ack_o, err_o);
      end
      cyc_i = 0; stb_i = 0;
      step();
      checks++;
      if (ack_o !== 1'b0) begin
         failures++; $display("FAIL wr_ack_one_cycle got ack=%b exp 0", ack_o);
      end
   endtask

   task automatic test_read_wait();
      cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 32'h100;
      step();
      checks++;
      if (htrans !== T_NSEQ || haddr !== 32'h100 || hwrite !== 1'b0) begin
         failures++; $display("FAIL rd_c1 got htrans=%b haddr=%h hwrite=%b exp 10/100/0", htrans, haddr, hwrite);
      end
      step();
      hready = 0;
      checks++;
      if (htrans !== T_IDLE || hwdata !== 32'h0) begin
         failures++; $display("FAIL rd_c2 got htrans=%b hwdata=%h exp 00/0", htrans, hwdata);
      end
      for (int c = 3; c <= 5; c++) begin
         step();
         if (c == 5) begin hready = 1; hrdata = 32'h12345678; end
         checks++;
         if (htrans !== T_IDLE || ack_o !== 1'b0) begin
            failures++; $display("FAIL rd_wait_c%0d got htrans=%b ack=%b exp 00/0", c, htrans, ack_o);
         end
      end
      step();
      checks++;
      if (ack_o !== 1'b1 || dat_o !== 32'h12345678) begin
         failures++; $display("FAIL rd_ack_c6 got ack=%b dat_o=%h exp 1/12345678", ack_o, dat_o);
      end
      cyc_i = 0; stb_i = 0; hrdata = 32'h0;
      step();
      checks++;
      if (ack_o !== 1'b0) begin
         failures++; $display("FAIL rd_ack_one_cycle got ack=%b exp 0", ack_o);
      end
   endtask

   task automatic test_error();
      cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 32'h200; hrdata = 32'hFFFF0000;
      step();
      step();
      hready = 0; hresp = R_ERR;
      step();
      hready = 1;
      checks++;
      if (ack_o !== 1'b0 || err_o !== 1'b0) begin
         failures++; $display("FAIL err_early got ack=%b err=%b exp 0/0", ack_o, err_o);
      end
      step();
      checks++;
      if (err_o !== 1'b1 || ack_o !== 1'b0 || dat_o !== 32'h12345678) begin
         failures++; $display("FAIL err_term got err=%b ack=%b dat_o=%h exp 1/0/12345678", err_o, ack_o, dat_o);
      end
      hresp = R_OKAY; cyc_i = 0; stb_i = 0; hrdata = 32'h0;
      step();
      checks++;
      if (err_o !== 1'b0 || ack_o !== 1'b0) begin
         failures++; $display("FAIL err_one_cycle got err=%b ack=%b exp 0/0", err_o, ack_o);
      end
   endtask

   task automatic test_retry(input int nret, input bit final_ok, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_dat);
      int nonseq;
      int iters;
      nonseq = 0;
      iters  = final_ok ? nret + 1 : nret;
      cyc_i = 1; stb_i = 1; we_i = 0; adr_i = a;
      for (int i = 0; i < iters; i++) begin
         step();
         if (htrans === T_NSEQ && haddr === a) nonseq++;
         checks++;
         if (ack_o !== 1'b0 || err_o !== 1'b0) begin
            failures++; $display("FAIL retry%0d_early_term issue %0d got ack=%b err=%b exp 0/0", nret, i, ack_o, err_o);
         end
         hready = 1; hresp = R_OKAY;
         step();
         if (i < nret) begin
            hready = 0; hresp = R_RTRY;
            step();
            hready = 1;
         end else begin
            hrdata = d;
         end
      end
      step();
      checks++;
      if (nonseq !== iters) begin
         failures++; $display("FAIL retry%0d_issues got %0d exp %0d", nret, nonseq, iters);
      end
      checks++;
      if (ack_o !== final_ok || err_o !== !final_ok || dat_o !== exp_dat || htrans !== T_IDLE) begin
         failures++; $display("FAIL retry%0d_term got ack=%b err=%b dat_o=%h htrans=%b exp %b/%b/%h/00",
                              nret, ack_o, err_o, dat_o, htrans, final_ok, !final_ok, exp_dat);
      end
      hready = 1; hresp = R_OKAY; hrdata = 32'h0; cyc_i = 0; stb_i = 0;
      step();
      checks++;
      if (ack_o !== 1'b0 || err_o !== 1'b0) begin
         failures++; $display("FAIL retry%0d_drop got ack=%b err=%b exp 0/0", nret, ack_o, err_o);
      end
   endtask

   task automatic test_back_to_back();
      int acks;
      int nonseq;
      acks = 0; nonseq = 0;
      cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 32'h500; dat_i = 32'h11110000;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (htrans === T_NSEQ) begin
            nonseq++;
            checks++;
            if (haddr !== 32'h500 + 32'h10 * acks) begin
               failures++; $display("FAIL b2b_haddr cycle %0d got %h exp %h", c, haddr, 32'h500 + 32'h10 * acks);
            end
         end
         if (acks < 3 && c == 2 + 4 * acks) begin
            checks++;
            if (hwdata !== 32'h11110000 + acks) begin
               failures++; $display("FAIL b2b_hwdata cycle %0d got %h exp %h", c, hwdata, 32'h11110000 + acks);
            end
         end
         if (ack_o === 1'b1) begin
            checks++;
            if (c != 3 + 4 * acks) begin
               failures++; $display("FAIL b2b_ack_cycle got %0d exp %0d", c, 3 + 4 * acks);
            end
            acks++;
            if (acks < 3) begin
               adr_i = 32'h500 + 32'h10 * acks; dat_i = 32'h11110000 + acks;
            end else begin
               cyc_i = 0; stb_i = 0;
            end
         end
      end
      checks++;
      if (nonseq != 3 || acks != 3) begin
         failures++; $display("FAIL b2b_counts got nonseq=%0d acks=%0d exp 3/3", nonseq, acks);
      end
   endtask

   task automatic test_cyc_drop();
      cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 32'h800; dat_i = 32'h55AA55AA;
      step();
      cyc_i = 0; stb_i = 0;
      step();
      checks++;
      if (hwdata !== 32'h55AA55AA) begin
         failures++; $display("FAIL drop_hwdata got %h exp 55aa55aa", hwdata);
      end
      for (int c = 3; c <= 4; c++) begin
         step();
         checks++;
         if (ack_o !== 1'b0 || err_o !== 1'b0 || htrans !== T_IDLE) begin
            failures++; $display("FAIL drop_suppress_c%0d got ack=%b err=%b htrans=%b exp 0/0/00", c, ack_o, err_o, htrans);
         end
      end
   endtask

   task automatic test_reset_mid();
      cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 32'h600;
      step();
      step();
      hready = 0;
      hresetn = 0; cyc_i = 0; stb_i = 0;
      #1;
      checks++;
      if (htrans !== T_IDLE || ack_o !== 1'b0 || haddr !== 32'h0 || dat_o !== 32'h0 || hwrite !== 1'b0) begin
         failures++; $display("FAIL rstmid_async got htrans=%b ack=%b haddr=%h dat_o=%h hwrite=%b exp 00/0/0/0/0",
                              htrans, ack_o, haddr, dat_o, hwrite);
      end
      @(posedge hclk);
      @(negedge hclk);
      hresetn = 1; hready = 1; hresp = R_OKAY;
      cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 32'h700;
      step();
      checks++;
      if (htrans !== T_NSEQ || haddr !== 32'h700) begin
         failures++; $display("FAIL rstmid_reissue got htrans=%b haddr=%h exp 10/700", htrans, haddr);
      end
      step();
      hrdata = 32'h0BADCAFE;
      step();
      checks++;
      if (ack_o !== 1'b1 || dat_o !== 32'h0BADCAFE) begin
         failures++; $display("FAIL rstmid_read got ack=%b dat_o=%h exp 1/0badcafe", ack_o, dat_o);
      end
      cyc_i = 0; stb_i = 0; hrdata = 32'h0;
      step();
   endtask

   initial begin
      hresetn = 0; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = '0; dat_i = '0;
      hready = 1; hrdata = '0; hresp = R_OKAY;
      test_reset();
      test_write();
      test_read_wait();
      test_error();
      test_retry(2, 1'b1, 32'h300, 32'hCAFEF00D, 32'hCAFEF00D);
      test_retry(4, 1'b0, 32'h340, 32'h0, 32'hCAFEF00D);
      test_back_to_back();
      test_cyc_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
